led_pulse_driver: RTL and testbench
===================================

Name: led_pulse_driver

Overview:
- Output-side counterpart of the front-panel button filter: it drives a user-visible indicator (LED or buzzer) instead of conditioning a user input.
- On a one-cycle START strobe it emits NUM timed pulses on LED_O, each ON_TICKS high and OFF_TICKS low.
- Pulse timing is measured in CE ticks from the shared clock-enable divider, so it matches the button-filter timebase.
- Sits between the control FSM, which issues START after a filtered button event, and the board pin.

Parameters:
CNT_W, 4, width of the on/off tick counter; ON_TICKS and OFF_TICKS must be in 1..2^CNT_W-1
ON_TICKS, 15, CE ticks LED_O is active per pulse
OFF_TICKS, 15, CE ticks LED_O is inactive after each pulse, including after the last pulse
NUM_W, 4, width of the pulse-count input
ACTIVE_LOW, 0, 1 = LED_O pin is inverted (active level 0)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
CE  in  1  clock-enable tick from the frequency divider, one CLK wide
START  in  1  one-cycle request strobe, sampled only in IDLE
NUM  in  NUM_W  pulse count, latched on an accepted START
ABORT  in  1  synchronous cancel of the current sequence
LED_O  out  1  indicator drive, registered
BUSY  out  1  high while a sequence runs, registered
DONE  out  1  one-CLK strobe on normal completion, registered

Behaviour:
- Reset (async): state=IDLE, tick counter=0, remaining=0, BUSY=0, DONE=0, LED_O=inactive level (0, or 1 if ACTIVE_LOW).
- All outputs are registered. "Active" means LED_O = ~ACTIVE_LOW.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - START=1 and NUM!=0 (ABORT=0): latch remaining=NUM, clear counter, go to ON. BUSY=1 and LED_O=active from the next edge.
  - START=1 and NUM=0: stay IDLE, DONE=1 for one cycle on the next edge, LED_O unchanged.
- ON:
  - Counter increments on each CE.
  - On CE with counter==ON_TICKS-1: clear counter, decrement remaining, go to OFF, LED_O=inactive.
  - CE asserted in the same cycle START is accepted is not counted.
- OFF:
  - Counter counts CE the same way.
  - On CE with counter==OFF_TICKS-1: clear counter. If remaining!=0, go to ON (LED_O active). If remaining==0, go to IDLE with BUSY=0 and DONE=1 for exactly one cycle.
- With CE held high, one sequence lasts NUM*(ON_TICKS+OFF_TICKS) cycles, from the first BUSY cycle through the edge where BUSY falls.
- START while BUSY: ignored, not queued. NUM changes while BUSY are ignored.
- ABORT=1 in any state: next edge goes to IDLE, LED_O inactive, BUSY=0, counter=0, remaining=0, no DONE. ABORT outranks a simultaneous START, so that START is dropped.
- Counter and remaining never wrap: each is cleared or decremented only at the transitions defined above.
- RST mid-sequence: immediate return to the reset state, no DONE.
- No CE pulses: the FSM holds its state indefinitely and LED_O holds its level.

Decomposition:
- Shared package: state encoding localparams (S_IDLE=2'd0, S_ON=2'd1, S_OFF=2'd2), and an LED_ACTIVE/LED_IDLE level helper derived from ACTIVE_LOW.
- One natural sub-module, led_tick_timer:
  - Contents: CE-gated CNT_W-bit counter, inputs CLR and LIMIT, one-cycle EXPIRE output (CE & cnt==LIMIT-1).
  - Reuse: the same counter shape as the debounce counter.
- Parent holds the FSM, remaining-count register and output registers.

Test Plan:
- CE=1 constantly, ON_TICKS=3, OFF_TICKS=2, START with NUM=2:
  - LED_O high 3 cycles, low 2, high 3, low 2.
  - BUSY high for exactly 10 cycles; DONE is one cycle, coincident with BUSY falling.
- CE every 4th cycle, ON_TICKS=2, OFF_TICKS=1, NUM=1:
  - LED_O high spans exactly 2 CE pulses, low spans 1.
  - A CE coincident with START is not counted; DONE appears after the 3rd counted CE.
- START with NUM=0 in IDLE -> DONE one cycle on the next edge; BUSY and LED_O stay 0.
- START with NUM=3, then a second START with NUM=5 during the 2nd pulse:
  - Exactly 3 pulses are emitted, followed by a single DONE.
- ABORT in mid-ON of pulse 2 of 4:
  - Next edge gives LED_O=0 and BUSY=0, with no DONE.
  - A START one cycle later with NUM=1 runs a clean single pulse.
- ACTIVE_LOW=1 variant: LED_O=1 at reset and during OFF/IDLE, 0 during ON.
  - RST asserted mid-sequence forces LED_O=1, BUSY=0 and DONE=0 asynchronously.

Source files
------------

// File: rtl/led_pulse_driver_pkg.sv
// Shared definitions for the LED/buzzer pulse driver: FSM encoding and pin-level helper.
// The pin polarity is resolved here so the datapath only deals in logical on/off.
package led_pulse_driver_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    // Physical pin level for a logical on/off request.
    function automatic logic led_level(input logic active_low, input logic on);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/led_tick_timer.sv
// CE-gated phase counter: counts clock-enable ticks and flags the tick that completes LIMIT of them.
// Same shape as the debounce counter; clears itself on expiry so back-to-back phases need no extra cycle.
module led_tick_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == limit - CNT_W'(1));
    // A tick arriving while cleared (e.g. the START cycle) is deliberately not counted.
    assign expire  = ce & ~clr & at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (ce) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pulse_driver.sv
// Emits NUM timed pulses on LED_O after a START strobe, timed in CE ticks.
// All outputs are registered; ABORT and RST cancel a sequence without a DONE strobe.
module led_pulse_driver
    import led_pulse_driver_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int ON_TICKS   = 15,
    parameter int OFF_TICKS  = 15,
    parameter int NUM_W      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             START,
    input  logic [NUM_W-1:0] NUM,
    input  logic             ABORT,
    output logic             LED_O,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic LED_ACTIVE = led_level(ACTIVE_LOW != 0, 1'b1);
    localparam logic LED_IDLE   = led_level(ACTIVE_LOW != 0, 1'b0);

    state_t           state, state_n;
    logic [NUM_W-1:0] remaining, remaining_n;
    logic             led_r, led_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;

    logic             tick_clr;
    logic             tick_expire;
    logic [CNT_W-1:0] tick_limit;

    // The counter is held clear whenever no phase is being timed.
    assign tick_clr   = (state == S_IDLE) || ABORT;
    assign tick_limit = (state == S_ON) ? CNT_W'(ON_TICKS) : CNT_W'(OFF_TICKS);

    led_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .ce     (CE),
        .clr    (tick_clr),
        .limit  (tick_limit),
        .expire (tick_expire)
    );

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        led_n       = led_r;
        busy_n      = busy_r;
        done_n      = 1'b0;

        if (ABORT) begin
            state_n     = S_IDLE;
            remaining_n = '0;
            led_n       = LED_IDLE;
            busy_n      = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (NUM != '0) begin
                            state_n     = S_ON;
                            remaining_n = NUM;
                            led_n       = LED_ACTIVE;
                            busy_n      = 1'b1;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (tick_expire) begin
                        state_n     = S_OFF;
                        remaining_n = remaining - NUM_W'(1);
                        led_n       = LED_IDLE;
                    end
                end
                S_OFF: begin
                    if (tick_expire) begin
                        if (remaining != '0) begin
                            state_n = S_ON;
                            led_n   = LED_ACTIVE;
                        end else begin
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n     = S_IDLE;
                    remaining_n = '0;
                    led_n       = LED_IDLE;
                    busy_n      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            remaining <= '0;
            led_r     <= LED_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            led_r     <= led_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
        end
    end

    assign LED_O = led_r;
    assign BUSY  = busy_r;
    assign DONE  = done_r;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Bench for led_pulse_driver: three parameter variants share one stimulus stream and are
// checked every cycle against a tick-position model, plus directed literal expectations.
module tb_led_pulse_driver;

    localparam int NINST = 3;
    // Variant 0: ON=3 OFF=2, 1: ON=2 OFF=1, 2: ON=3 OFF=2 active-low.
    localparam int ON_T  [NINST] = '{3, 2, 3};
    localparam int OFF_T [NINST] = '{2, 1, 2};
    localparam int AL_T  [NINST] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       start;
    logic [3:0] num;
    logic       abort;
    logic       led_w  [NINST];
    logic       busy_w [NINST];
    logic       done_w [NINST];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pulse_driver #(.CNT_W(4), .ON_TICKS(3), .OFF_TICKS(2), .NUM_W(4), .ACTIVE_LOW(0)) dut_a (
        .CLK(clk), .RST(rst), .CE(ce), .START(start), .NUM(num), .ABORT(abort),
        .LED_O(led_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]));
    led_pulse_driver #(.CNT_W(4), .ON_TICKS(2), .OFF_TICKS(1), .NUM_W(4), .ACTIVE_LOW(0)) dut_b (
        .CLK(clk), .RST(rst), .CE(ce), .START(start), .NUM(num), .ABORT(abort),
        .LED_O(led_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]));
    led_pulse_driver #(.CNT_W(4), .ON_TICKS(3), .OFF_TICKS(2), .NUM_W(4), .ACTIVE_LOW(1)) dut_c (
        .CLK(clk), .RST(rst), .CE(ce), .START(start), .NUM(num), .ABORT(abort),
        .LED_O(led_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]));

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a sequence is a run of num*(ON+OFF) counted CE ticks; the LED is on while the
    // tick position within the current period is below ON.
    bit m_busy [NINST] = '{0, 0, 0};
    bit m_done [NINST] = '{0, 0, 0};
    int m_k    [NINST] = '{0, 0, 0};
    int m_tot  [NINST] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < NINST; i++) begin
                m_done[i] = 1'b0;
                if (rst) begin
                    m_busy[i] = 1'b0;
                    m_k[i]    = 0;
                end else if (abort) begin
                    m_busy[i] = 1'b0;
                    m_k[i]    = 0;
                end else if (!m_busy[i]) begin
                    if (start) begin
                        if (num != 0) begin
                            m_busy[i] = 1'b1;
                            m_k[i]    = 0;
                            m_tot[i]  = int'(num) * (ON_T[i] + OFF_T[i]);
                        end else begin
                            m_done[i] = 1'b1;
                        end
                    end
                end else if (ce) begin
                    m_k[i] = m_k[i] + 1;
                    if (m_k[i] == m_tot[i]) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic int exp_led(input int i);
        int on;
        on = (m_busy[i] && ((m_k[i] % (ON_T[i] + OFF_T[i])) < ON_T[i])) ? 1 : 0;
        return on ^ AL_T[i];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NINST; i++) begin
                chk($sformatf("model_led[%0d]", i),  int'(led_w[i]),  exp_led(i));
                chk($sformatf("model_busy[%0d]", i), int'(busy_w[i]), int'(m_busy[i]));
                chk($sformatf("model_done[%0d]", i), int'(done_w[i]), int'(m_done[i]));
            end
        end
    end

    initial begin
        int pat, busy_cnt, done_cnt, done_i, hi_cnt, rises;
        logic prev;
        rst = 1'b1; ce = 1'b0; start = 1'b0; num = '0; abort = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_led_a", int'(led_w[0]), 0);
        chk("rst_busy_a", int'(busy_w[0]), 0);
        chk("rst_done_a", int'(done_w[0]), 0);
        chk("rst_led_c", int'(led_w[2]), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: CE always high, NUM=2
        start = 1'b1; num = 4'd2; ce = 1'b1;
        pat = 0; busy_cnt = 0; done_cnt = 0; done_i = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i < 10) pat = (pat << 1) | int'(led_w[0]);
            if (busy_w[0]) busy_cnt++;
            if (done_w[0]) begin done_cnt++; done_i = i; end
            if (i == 10) chk("t1_busy_at_done", int'(busy_w[0]), 0);
        end
        chk("t1_led_pattern", pat, 10'b1110011100);
        chk("t1_busy_cycles", busy_cnt, 10);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_done_index", done_i, 10);

        // Test 2: CE every 4th cycle, coincident with START
        @(negedge clk);
        start = 1'b1; num = 4'd1; ce = 1'b1;
        hi_cnt = 0; busy_cnt = 0; done_cnt = 0; done_i = -1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            start = 1'b0;
            ce = (i % 4 == 0);
            if (led_w[1]) hi_cnt++;
            if (busy_w[1]) busy_cnt++;
            if (done_w[1]) begin done_cnt++; done_i = i; end
        end
        chk("t2_led_high_cycles", hi_cnt, 8);
        chk("t2_busy_cycles", busy_cnt, 12);
        chk("t2_done_count", done_cnt, 1);
        chk("t2_done_index", done_i, 13);

        // Test 3: START with NUM=0
        @(negedge clk);
        ce = 1'b1; start = 1'b1; num = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t3_done", int'(done_w[0]), 1);
        chk("t3_busy", int'(busy_w[0]), 0);
        chk("t3_led", int'(led_w[0]), 0);
        @(negedge clk);
        chk("t3_done_one_cycle", int'(done_w[0]), 0);

        // Test 4: second START during pulse 2 is ignored
        start = 1'b1; num = 4'd3;
        rises = 0; done_cnt = 0; prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = (i == 6);
            num   = (i == 6) ? 4'd5 : 4'd3;
            if (led_w[0] && !prev) rises++;
            prev = led_w[0];
            if (done_w[0]) done_cnt++;
        end
        chk("t4_pulses", rises, 3);
        chk("t4_done_count", done_cnt, 1);

        // Test 5: ABORT mid-ON of pulse 2 of 4, then a clean single pulse
        start = 1'b1; num = 4'd4;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 6) begin
                chk("t5_led_before_abort", int'(led_w[0]), 1);
                abort = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        chk("t5_led_after_abort", int'(led_w[0]), 0);
        chk("t5_busy_after_abort", int'(busy_w[0]), 0);
        chk("t5_no_done", int'(done_w[0]), 0);
        chk("t5_led_c_after_abort", int'(led_w[2]), 1);
        start = 1'b1; num = 4'd1;
        hi_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (led_w[0]) hi_cnt++;
            if (done_w[0]) done_cnt++;
        end
        chk("t5_rerun_high", hi_cnt, 3);
        chk("t5_rerun_done", done_cnt, 1);

        // Test 6: active-low variant, asynchronous reset mid-sequence
        start = 1'b1; num = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_led_c_on", int'(led_w[2]), 0);
        chk("t6_busy_c", int'(busy_w[2]), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_led_c", int'(led_w[2]), 1);
        chk("t6_async_busy_c", int'(busy_w[2]), 0);
        chk("t6_async_done_c", int'(done_w[2]), 0);
        chk("t6_async_led_a", int'(led_w[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_idle_led_c", int'(led_w[2]), 1);
        chk("t6_idle_busy_c", int'(busy_w[2]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
